reorder_buffer_ss: RTL and testbench
====================================

Name: reorder_buffer_ss

Overview:
Parametrised superscalar reorder buffer. It accepts up to WIDTH in-order dispatches per cycle and CDB_PORTS completions per cycle. It commits up to WIDTH ready entries per cycle, in order, to the register file. It sits between the dispatcher/RS, the CDB and the architectural register file, and raises a precise flush when a mispredicted branch retires.

Parameters:
DEPTH, 16, number of entries; power of 2, at least 4; TAG_W = log2(DEPTH)
WIDTH, 2, dispatch lanes and commit lanes; 1..4, at most DEPTH/2
CDB_PORTS, 2, completion write ports
XLEN, 32, data/PC width
REG_ADDR_LEN, 5, architectural register address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
dispatch_valid  in  WIDTH  per-lane dispatch request; must be contiguous from lane 0
dispatch_dest_en  in  WIDTH  lane writes a destination register
dispatch_dest  in  WIDTH*REG_ADDR_LEN  destination register per lane
dispatch_pc  in  WIDTH*XLEN  PC per lane
dispatch_npc  in  WIDTH*XLEN  predicted next PC per lane
dispatch_tag  out  WIDTH*TAG_W  tag assigned per lane; lane i gets tail+i
free_slots  out  TAG_W+1  DEPTH minus count, from registered state only
cdb_valid  in  CDB_PORTS  completion strobe
cdb_tag  in  CDB_PORTS*TAG_W  completing tag
cdb_data  in  CDB_PORTS*XLEN  result
cdb_mispredict  in  CDB_PORTS  branch resolved opposite to prediction
cdb_target  in  CDB_PORTS*XLEN  correct next PC (used when mispredict)
search_tag  in  2*WIDTH*TAG_W  operand lookup tags
search_ready  out  2*WIDTH  entry has a result (includes same-cycle CDB bypass)
search_data  out  2*WIDTH*XLEN  result value (bypassed)
commit_valid  out  WIDTH  lane retires this cycle; contiguous from lane 0
commit_wb_en  out  WIDTH  commit_valid AND entry dest_en
commit_reg  out  WIDTH*REG_ADDR_LEN  destination register
commit_data  out  WIDTH*XLEN  result
commit_tag  out  WIDTH*TAG_W  retiring tag
commit_pc  out  WIDTH*XLEN  retiring PC
flush  out  1  mispredicted branch retires this cycle
flush_pc  out  XLEN  redirect target (entry cdb_target)
overflow_err  out  1  sticky; set when dispatch exceeds free_slots

Behaviour:
- State: entry array {valid, ready, mispredict, dest_en, dest, data, pc, npc/target}, plus head, tail (TAG_W, natural wrap) and count (TAG_W+1).
- Reset (reset=0, async): head=tail=count=0, all valid/ready/mispredict=0, overflow_err=0. All outputs are combinational from state: commit_*, flush, search_ready = 0; free_slots = DEPTH.
- Dispatch:
  - n = popcount(dispatch_valid).
  - Accepted only if n <= free_slots; the whole group is rejected otherwise and overflow_err is set.
  - Lane i writes entry tail+i with valid=1, ready=0, mispredict=0.
  - tail += n.
  - dispatch_tag is always driven as tail+i.
  - free_slots takes no credit from same-cycle commits.
- CDB:
  - Each cdb_valid port with a valid entry sets ready=1, data, mispredict; npc is replaced by cdb_target when cdb_mispredict=1.
  - A CDB to an invalid entry is ignored.
  - When two ports carry the same tag, the lower port index wins.
- Search: combinational. On a current-cycle CDB tag match, returns the CDB value with search_ready=1; otherwise returns the entry value. search_ready=0 for invalid entries.
- Commit:
  - Lane k retires entry head+k when lanes 0..k-1 retired, the entry is valid and ready, k < count, and no earlier lane this cycle was mispredicted.
  - A CDB write is visible to commit the cycle after it arrives (no same-cycle commit bypass).
  - head += m; count += n - m.
- Flush:
  - If a committing lane's entry has mispredict=1, that lane is the last commit lane and flush=1 with flush_pc = its npc.
  - At that edge: all entries are invalidated, tail=head_new, count=0, and same-cycle dispatch and CDB writes are discarded.
  - No flush at head of an empty ROB.
- Full: count==DEPTH, free_slots=0.
- Empty: count==0, commit_valid=0.
- Wrap-around of head and tail is by natural TAG_W overflow.
- Reset asserted mid-operation discards all in-flight state immediately.

Test Plan:
- DEPTH=8, WIDTH=2. Reset, then dispatch 2 lanes (dest r1, r2) -> tags 0,1; free_slots 8->6 next cycle; no commit.
- CDB tag1 data 0x22, then next cycle tag0 data 0x11 -> the following cycle commit_valid=2'b11, commit_reg r1,r2, data 0x11,0x22; free_slots=8.
- Fill to 8 entries, dispatch 1 more -> free_slots=0, entry rejected, overflow_err=1 sticky, count stays 8.
- Wrap-around: run 12 dispatch/commit pairs -> tags wrap 7->0, commit order preserved, head==tail when empty.
- Mispredict: tags 0 (branch, mispredict target 0x400), 1, 2 all ready, plus a dispatch in the same cycle -> commit lane0 only, flush=1, flush_pc=0x400; next cycle count=0, free_slots=8, and the dispatch is dropped.
- Search bypass: search tag3 while cdb_valid on tag3 data 0xABCD -> search_ready=1, search_data=0xABCD in the same cycle; assert reset mid-burst -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/reorder_buffer_ss.sv
// Superscalar reorder buffer: WIDTH-wide in-order dispatch and commit, CDB_PORTS
// completion ports, operand search with same-cycle CDB bypass, precise branch flush.
module reorder_buffer_ss #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 2,
   parameter int CDB_PORTS = 2,
   parameter int XLEN = 32,
   parameter int REG_ADDR_LEN = 5,
   localparam int TAG_W = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [WIDTH-1:0]                dispatch_valid,
   input  logic [WIDTH-1:0]                dispatch_dest_en,
   input  logic [WIDTH*REG_ADDR_LEN-1:0]   dispatch_dest,
   input  logic [WIDTH*XLEN-1:0]           dispatch_pc,
   input  logic [WIDTH*XLEN-1:0]           dispatch_npc,
   output logic [WIDTH*TAG_W-1:0]          dispatch_tag,
   output logic [TAG_W:0]                  free_slots,
   input  logic [CDB_PORTS-1:0]            cdb_valid,
   input  logic [CDB_PORTS*TAG_W-1:0]      cdb_tag,
   input  logic [CDB_PORTS*XLEN-1:0]       cdb_data,
   input  logic [CDB_PORTS-1:0]            cdb_mispredict,
   input  logic [CDB_PORTS*XLEN-1:0]       cdb_target,
   input  logic [2*WIDTH*TAG_W-1:0]        search_tag,
   output logic [2*WIDTH-1:0]              search_ready,
   output logic [2*WIDTH*XLEN-1:0]         search_data,
   output logic [WIDTH-1:0]                commit_valid,
   output logic [WIDTH-1:0]                commit_wb_en,
   output logic [WIDTH*REG_ADDR_LEN-1:0]   commit_reg,
   output logic [WIDTH*XLEN-1:0]           commit_data,
   output logic [WIDTH*TAG_W-1:0]          commit_tag,
   output logic [WIDTH*XLEN-1:0]           commit_pc,
   output logic                            flush,
   output logic [XLEN-1:0]                 flush_pc,
   output logic                            overflow_err
);

   // Handshake: a dispatch group is taken in full on the clock edge when its lane
   // count fits in free_slots, otherwise dropped whole; there is no per-lane backpressure.
   logic [DEPTH-1:0]        valid_q, ready_q, mispred_q, dest_en_q;
   logic [REG_ADDR_LEN-1:0] dest_q [DEPTH];
   logic [XLEN-1:0]         data_q [DEPTH];
   logic [XLEN-1:0]         pc_q   [DEPTH];
   logic [XLEN-1:0]         npc_q  [DEPTH];
   logic [TAG_W-1:0]        head, tail;
   logic [TAG_W:0]          count, n_disp, n_commit;
   logic                    accept, go;
   logic [TAG_W-1:0]        idx, s_tag;

   always_comb begin
      n_disp = '0;
      dispatch_tag = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n_disp = n_disp + (TAG_W+1)'(dispatch_valid[i]);
         dispatch_tag[i*TAG_W +: TAG_W] = tail + TAG_W'(i);
      end
      free_slots = (TAG_W+1)'(DEPTH) - count;
      accept = (n_disp <= free_slots);
   end

   // Commit stops after the first non-retiring lane and after a mispredicted one.
   always_comb begin
      commit_valid = '0;
      commit_wb_en = '0;
      commit_reg   = '0;
      commit_data  = '0;
      commit_tag   = '0;
      commit_pc    = '0;
      flush        = 1'b0;
      flush_pc     = '0;
      n_commit     = '0;
      go           = 1'b1;
      idx          = '0;
      for (int k = 0; k < WIDTH; k++) begin
         idx = head + TAG_W'(k);
         if (go && valid_q[idx] && ready_q[idx] && ((TAG_W+1)'(k) < count)) begin
            commit_valid[k] = 1'b1;
            commit_wb_en[k] = dest_en_q[idx];
            commit_reg[k*REG_ADDR_LEN +: REG_ADDR_LEN] = dest_q[idx];
            commit_data[k*XLEN +: XLEN] = data_q[idx];
            commit_tag[k*TAG_W +: TAG_W] = idx;
            commit_pc[k*XLEN +: XLEN] = pc_q[idx];
            n_commit = n_commit + 1'b1;
            if (mispred_q[idx]) begin
               flush    = 1'b1;
               flush_pc = npc_q[idx];
               go       = 1'b0;
            end
         end else begin
            go = 1'b0;
         end
      end
   end

   always_comb begin
      search_ready = '0;
      search_data  = '0;
      s_tag        = '0;
      for (int s = 0; s < 2*WIDTH; s++) begin
         s_tag = search_tag[s*TAG_W +: TAG_W];
         search_ready[s] = valid_q[s_tag] & ready_q[s_tag];
         search_data[s*XLEN +: XLEN] = data_q[s_tag];
         for (int p = CDB_PORTS-1; p >= 0; p--) begin
            if (cdb_valid[p] && valid_q[s_tag] && (cdb_tag[p*TAG_W +: TAG_W] == s_tag)) begin
               search_ready[s] = 1'b1;
               search_data[s*XLEN +: XLEN] = cdb_data[p*XLEN +: XLEN];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q      <= '0;
         ready_q      <= '0;
         mispred_q    <= '0;
         dest_en_q    <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
         for (int e = 0; e < DEPTH; e++) begin
            dest_q[e] <= '0;
            data_q[e] <= '0;
            pc_q[e]   <= '0;
            npc_q[e]  <= '0;
         end
      end else begin
         if (!accept) overflow_err <= 1'b1;
         if (flush) begin
            valid_q   <= '0;
            ready_q   <= '0;
            mispred_q <= '0;
            head      <= head + n_commit[TAG_W-1:0];
            tail      <= head + n_commit[TAG_W-1:0];
            count     <= '0;
         end else begin
            // Descending port order lets the lower port's write land last.
            for (int p = CDB_PORTS-1; p >= 0; p--) begin
               if (cdb_valid[p] && valid_q[cdb_tag[p*TAG_W +: TAG_W]]) begin
                  ready_q[cdb_tag[p*TAG_W +: TAG_W]]   <= 1'b1;
                  data_q[cdb_tag[p*TAG_W +: TAG_W]]    <= cdb_data[p*XLEN +: XLEN];
                  mispred_q[cdb_tag[p*TAG_W +: TAG_W]] <= cdb_mispredict[p];
                  if (cdb_mispredict[p])
                     npc_q[cdb_tag[p*TAG_W +: TAG_W]] <= cdb_target[p*XLEN +: XLEN];
               end
            end
            for (int k = 0; k < WIDTH; k++) begin
               if (commit_valid[k]) begin
                  valid_q[head + TAG_W'(k)] <= 1'b0;
                  ready_q[head + TAG_W'(k)] <= 1'b0;
               end
            end
            if (accept) begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (dispatch_valid[i]) begin
                     valid_q[tail + TAG_W'(i)]   <= 1'b1;
                     ready_q[tail + TAG_W'(i)]   <= 1'b0;
                     mispred_q[tail + TAG_W'(i)] <= 1'b0;
                     dest_en_q[tail + TAG_W'(i)] <= dispatch_dest_en[i];
                     dest_q[tail + TAG_W'(i)]    <= dispatch_dest[i*REG_ADDR_LEN +: REG_ADDR_LEN];
                     pc_q[tail + TAG_W'(i)]      <= dispatch_pc[i*XLEN +: XLEN];
                     npc_q[tail + TAG_W'(i)]     <= dispatch_npc[i*XLEN +: XLEN];
                  end
               end
            end
            head  <= head + n_commit[TAG_W-1:0];
            tail  <= tail + (accept ? n_disp[TAG_W-1:0] : '0);
            count <= count + (accept ? n_disp : '0) - n_commit;
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer_ss.sv
// Bench for reorder_buffer_ss (DEPTH=8, WIDTH=2): directed scenarios then random
// traffic, all outputs compared each cycle against a queue-based ROB model.
module tb_reorder_buffer_ss;
   localparam int DEPTH = 8;
   localparam int WIDTH = 2;
   localparam int CP = 2;
   localparam int XLEN = 32;
   localparam int RL = 5;
   localparam int TW = 3;
   localparam int NS = 2*WIDTH;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic [WIDTH-1:0]      dispatch_valid, dispatch_dest_en;
   logic [WIDTH*RL-1:0]   dispatch_dest;
   logic [WIDTH*XLEN-1:0] dispatch_pc, dispatch_npc;
   logic [WIDTH*TW-1:0]   dispatch_tag;
   logic [TW:0]           free_slots;
   logic [CP-1:0]         cdb_valid, cdb_mispredict;
   logic [CP*TW-1:0]      cdb_tag;
   logic [CP*XLEN-1:0]    cdb_data, cdb_target;
   logic [NS*TW-1:0]      search_tag;
   logic [NS-1:0]         search_ready;
   logic [NS*XLEN-1:0]    search_data;
   logic [WIDTH-1:0]      commit_valid, commit_wb_en;
   logic [WIDTH*RL-1:0]   commit_reg;
   logic [WIDTH*XLEN-1:0] commit_data, commit_pc;
   logic [WIDTH*TW-1:0]   commit_tag;
   logic                  flush, overflow_err;
   logic [XLEN-1:0]       flush_pc;

   reorder_buffer_ss #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CDB_PORTS(CP), .XLEN(XLEN), .REG_ADDR_LEN(RL)) dut (
      .clk(clk), .reset(reset),
      .dispatch_valid(dispatch_valid), .dispatch_dest_en(dispatch_dest_en),
      .dispatch_dest(dispatch_dest), .dispatch_pc(dispatch_pc), .dispatch_npc(dispatch_npc),
      .dispatch_tag(dispatch_tag), .free_slots(free_slots),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
      .search_tag(search_tag), .search_ready(search_ready), .search_data(search_data),
      .commit_valid(commit_valid), .commit_wb_en(commit_wb_en), .commit_reg(commit_reg),
      .commit_data(commit_data), .commit_tag(commit_tag), .commit_pc(commit_pc),
      .flush(flush), .flush_pc(flush_pc), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   // Reference model: in-flight entries held oldest-first; tag = (head_ptr + position) mod DEPTH.
   typedef struct {
      logic            ready, mispred, dest_en;
      logic [RL-1:0]   dest;
      logic [XLEN-1:0] data, pc, npc;
   } ent_t;
   ent_t mq[$];
   int   head_ptr;
   bit   m_ovf;
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_commits(output bit fl, output logic [XLEN-1:0] fpc);
      int m = 0;
      fl = 1'b0;
      fpc = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (k >= mq.size()) break;
         if (!mq[k].ready) break;
         m++;
         if (mq[k].mispred) begin
            fl = 1'b1;
            fpc = mq[k].npc;
            break;
         end
      end
      return m;
   endfunction

   task automatic model_reset();
      mq.delete();
      head_ptr = 0;
      m_ovf = 1'b0;
   endtask

   task automatic compare_outputs();
      bit fl;
      logic [XLEN-1:0] fpc;
      int m, pos, sz;
      logic [WIDTH-1:0] ecv, ewb;
      logic [TW-1:0] t;
      logic er, found;
      logic [XLEN-1:0] ed;
      m = model_commits(fl, fpc);
      sz = mq.size();
      chk("free_slots", 64'(free_slots), 64'(DEPTH - sz));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      for (int i = 0; i < WIDTH; i++)
         chk("dispatch_tag", 64'(dispatch_tag[i*TW +: TW]), 64'((head_ptr + sz + i) % DEPTH));
      ecv = '0;
      ewb = '0;
      for (int k = 0; k < m; k++) begin
         ecv[k] = 1'b1;
         ewb[k] = mq[k].dest_en;
      end
      chk("commit_valid", 64'(commit_valid), 64'(ecv));
      chk("commit_wb_en", 64'(commit_wb_en), 64'(ewb));
      chk("flush", 64'(flush), 64'(fl));
      if (fl) chk("flush_pc", 64'(flush_pc), 64'(fpc));
      for (int k = 0; k < m; k++) begin
         chk("commit_reg", 64'(commit_reg[k*RL +: RL]), 64'(mq[k].dest));
         chk("commit_data", 64'(commit_data[k*XLEN +: XLEN]), 64'(mq[k].data));
         chk("commit_pc", 64'(commit_pc[k*XLEN +: XLEN]), 64'(mq[k].pc));
         chk("commit_tag", 64'(commit_tag[k*TW +: TW]), 64'((head_ptr + k) % DEPTH));
      end
      for (int s = 0; s < NS; s++) begin
         t = search_tag[s*TW +: TW];
         pos = (int'(t) - head_ptr + DEPTH) % DEPTH;
         er = 1'b0;
         ed = '0;
         found = 1'b0;
         if (pos < sz) begin
            er = mq[pos].ready;
            ed = mq[pos].data;
            for (int p = 0; p < CP; p++) begin
               if (!found && cdb_valid[p] && cdb_tag[p*TW +: TW] == t) begin
                  er = 1'b1;
                  ed = cdb_data[p*XLEN +: XLEN];
                  found = 1'b1;
               end
            end
         end
         chk("search_ready", 64'(search_ready[s]), 64'(er));
         if (er) chk("search_data", 64'(search_data[s*XLEN +: XLEN]), 64'(ed));
      end
   endtask

   task automatic model_update();
      bit fl;
      logic [XLEN-1:0] fpc;
      int m, n, sz, pos;
      bit taken [CP];
      ent_t e;
      m = model_commits(fl, fpc);
      n = $countones(dispatch_valid);
      sz = mq.size();
      if (n > DEPTH - sz) m_ovf = 1'b1;
      if (fl) begin
         head_ptr = (head_ptr + m) % DEPTH;
         mq.delete();
      end else begin
         for (int p = 0; p < CP; p++) begin
            taken[p] = 1'b0;
            for (int q = 0; q < p; q++)
               if (cdb_valid[q] && cdb_tag[q*TW +: TW] == cdb_tag[p*TW +: TW]) taken[p] = 1'b1;
            pos = (int'(cdb_tag[p*TW +: TW]) - head_ptr + DEPTH) % DEPTH;
            if (cdb_valid[p] && !taken[p] && pos < sz) begin
               e = mq[pos];
               e.ready = 1'b1;
               e.data = cdb_data[p*XLEN +: XLEN];
               e.mispred = cdb_mispredict[p];
               if (cdb_mispredict[p]) e.npc = cdb_target[p*XLEN +: XLEN];
               mq[pos] = e;
            end
         end
         repeat (m) void'(mq.pop_front());
         head_ptr = (head_ptr + m) % DEPTH;
         if (n <= DEPTH - sz) begin
            for (int i = 0; i < n; i++) begin
               e.ready = 1'b0;
               e.mispred = 1'b0;
               e.dest_en = dispatch_dest_en[i];
               e.dest = dispatch_dest[i*RL +: RL];
               e.data = '0;
               e.pc = dispatch_pc[i*XLEN +: XLEN];
               e.npc = dispatch_npc[i*XLEN +: XLEN];
               mq.push_back(e);
            end
         end
      end
   endtask

   task automatic idle();
      dispatch_valid = '0;
      dispatch_dest_en = '0;
      dispatch_dest = '0;
      dispatch_pc = '0;
      dispatch_npc = '0;
      cdb_valid = '0;
      cdb_tag = '0;
      cdb_data = '0;
      cdb_mispredict = '0;
      cdb_target = '0;
      search_tag = '0;
   endtask

   task automatic disp_lane(input int i, input logic [RL-1:0] d, input logic [XLEN-1:0] pc);
      dispatch_valid[i] = 1'b1;
      dispatch_dest_en[i] = 1'b1;
      dispatch_dest[i*RL +: RL] = d;
      dispatch_pc[i*XLEN +: XLEN] = pc;
      dispatch_npc[i*XLEN +: XLEN] = pc + 32'd4;
   endtask

   task automatic cdb_port(input int p, input logic [TW-1:0] t, input logic [XLEN-1:0] d,
                           input logic mp, input logic [XLEN-1:0] tgt);
      cdb_valid[p] = 1'b1;
      cdb_tag[p*TW +: TW] = t;
      cdb_data[p*XLEN +: XLEN] = d;
      cdb_mispredict[p] = mp;
      cdb_target[p*XLEN +: XLEN] = tgt;
   endtask

   task automatic settle();
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      compare_outputs();
      chk("rst_free", 64'(free_slots), 64'(DEPTH));
      chk("rst_commit", 64'(commit_valid), 64'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int p;
      for (int c = 0; c < 40 && mq.size() > 0; c++) begin
         idle();
         p = 0;
         for (int k = 0; k < mq.size() && p < CP; k++) begin
            if (!mq[k].ready) begin
               cdb_port(p, TW'((head_ptr + k) % DEPTH), 32'hD000 + 32'(k), 1'b0, '0);
               p++;
            end
         end
         step();
      end
      idle();
      settle();
      chk("drain_free", 64'(free_slots), 64'(DEPTH));
      tick();
   endtask

   task automatic drive_random();
      int n, pos;
      idle();
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         disp_lane(i, RL'($urandom_range(0, 31)), $urandom);
         dispatch_dest_en[i] = 1'($urandom_range(0, 1));
      end
      for (int p = 0; p < CP; p++) begin
         if ($urandom_range(0, 9) < 7) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
               pos = $urandom_range(0, mq.size() - 1);
               cdb_port(p, TW'((head_ptr + pos) % DEPTH), $urandom, 1'($urandom_range(0, 9) == 0), $urandom);
            end else begin
               cdb_port(p, TW'($urandom_range(0, DEPTH-1)), $urandom, 1'b0, '0);
            end
         end
      end
      for (int s = 0; s < NS; s++) search_tag[s*TW +: TW] = TW'($urandom_range(0, DEPTH-1));
   endtask

   initial begin
      idle();
      model_reset();
      @(posedge clk);
      do_reset();

      // Two-lane dispatch, out-of-order completion, dual commit.
      idle(); disp_lane(0, 5'd1, 32'h100); disp_lane(1, 5'd2, 32'h104);
      settle();
      chk("t1_tags", 64'(dispatch_tag), 64'(6'b001_000));
      chk("t1_free_pre", 64'(free_slots), 64'd8);
      tick();
      idle(); settle();
      chk("t1_free_post", 64'(free_slots), 64'd6);
      chk("t1_no_commit", 64'(commit_valid), 64'd0);
      tick();
      idle(); cdb_port(0, 3'd1, 32'h22, 1'b0, '0); step();
      idle(); cdb_port(0, 3'd0, 32'h11, 1'b0, '0);
      settle();
      chk("t2_no_bypass_commit", 64'(commit_valid), 64'd0);
      tick();
      idle(); settle();
      chk("t2_commit_valid", 64'(commit_valid), 64'(2'b11));
      chk("t2_commit_reg", 64'(commit_reg), 64'({5'd2, 5'd1}));
      chk("t2_commit_data", 64'(commit_data), {32'h22, 32'h11});
      tick();
      idle(); settle();
      chk("t2_free", 64'(free_slots), 64'd8);
      tick();

      // Fill to full, then overflow with one more lane.
      for (int j = 0; j < 4; j++) begin
         idle(); disp_lane(0, RL'(j), 32'h500 + 32'(8*j)); disp_lane(1, RL'(j+8), 32'h504 + 32'(8*j));
         step();
      end
      idle(); disp_lane(0, 5'd20, 32'h600);
      settle();
      chk("t3_full", 64'(free_slots), 64'd0);
      tick();
      idle(); settle();
      chk("t3_overflow", 64'(overflow_err), 64'd1);
      chk("t3_still_full", 64'(free_slots), 64'd0);
      tick();
      drain();
      idle(); settle();
      chk("t3_sticky", 64'(overflow_err), 64'd1);
      tick();

      // Wrap-around through twelve single dispatch/commit pairs.
      for (int j = 0; j < 12; j++) begin
         idle(); disp_lane(0, RL'(j+1), 32'h200 + 32'(4*j)); step();
         idle(); cdb_port(0, TW'((head_ptr + mq.size() - 1) % DEPTH), 32'h1000 + 32'(j), 1'b0, '0); step();
         idle(); step();
      end
      idle(); settle();
      chk("t4_empty", 64'(free_slots), 64'd8);
      chk("t4_tail", 64'(dispatch_tag), 64'({3'd7, 3'd6}));
      tick();

      // Mispredicted branch at head with younger ready entries and a same-cycle dispatch.
      do_reset();
      idle(); disp_lane(0, 5'd3, 32'h300); disp_lane(1, 5'd4, 32'h304); step();
      idle(); disp_lane(0, 5'd5, 32'h308); step();
      idle(); cdb_port(0, 3'd1, 32'hA1, 1'b0, '0); cdb_port(1, 3'd2, 32'hA2, 1'b0, '0);
      settle();
      chk("t5_wait_head", 64'(commit_valid), 64'd0);
      tick();
      idle(); cdb_port(0, 3'd0, 32'hB0, 1'b1, 32'h400); step();
      idle(); disp_lane(0, 5'd6, 32'h30C);
      settle();
      chk("t5_commit_lane0", 64'(commit_valid), 64'(2'b01));
      chk("t5_flush", 64'(flush), 64'd1);
      chk("t5_flush_pc", 64'(flush_pc), 64'h400);
      tick();
      idle(); settle();
      chk("t5_free", 64'(free_slots), 64'd8);
      chk("t5_no_commit", 64'(commit_valid), 64'd0);
      tick();

      // Search bypass on tag 3, then asynchronous reset mid-burst.
      idle(); disp_lane(0, 5'd7, 32'h700); disp_lane(1, 5'd8, 32'h704); step();
      idle(); disp_lane(0, 5'd9, 32'h708); disp_lane(1, 5'd10, 32'h70C); step();
      idle(); cdb_port(1, 3'd3, 32'hABCD, 1'b0, '0); cdb_port(0, 3'd1, 32'h55, 1'b0, '0);
      search_tag[0 +: TW] = 3'd3; search_tag[TW +: TW] = 3'd1; search_tag[2*TW +: TW] = 3'd4;
      settle();
      chk("t6_search_ready", 64'(search_ready[0]), 64'd1);
      chk("t6_search_data", 64'(search_data[0 +: XLEN]), 64'hABCD);
      chk("t6_search_pending", 64'(search_ready[2]), 64'd0);
      tick();
      idle(); cdb_port(0, 3'd2, 32'h66, 1'b0, '0); search_tag[0 +: TW] = 3'd3; step();
      idle(); disp_lane(0, 5'd11, 32'h710); disp_lane(1, 5'd12, 32'h714); search_tag[0 +: TW] = 3'd3;
      settle();
      chk("t6_pre_reset_commit", 64'(commit_valid), 64'(2'b11));
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_commit", 64'(commit_valid), 64'd0);
      chk("t6_rst_wb_en", 64'(commit_wb_en), 64'd0);
      chk("t6_rst_flush", 64'(flush), 64'd0);
      chk("t6_rst_free", 64'(free_slots), 64'd8);
      chk("t6_rst_search", 64'(search_ready), 64'd0);
      chk("t6_rst_ovf", 64'(overflow_err), 64'd0);
      idle();
      model_reset();
      @(negedge clk);
      compare_outputs();
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         drive_random();
         step();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
